router_pkt_fifo: RTL
====================

Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware successor to the router's per-port output FIFO; one instance per destination port of the 1xN router.
- Stores bytes written by the router FSM, tagging header bytes via lfd_state.
- Tracks packet boundaries on both sides, reports the number of complete packets held, and flags start and end of packet on the read side.
- Adds almost-full, overflow/underflow flags and packet count; soft_reset flushes the FIFO when a port times out.

Parameters:
- DATA_WIDTH, 8, byte width; header layout is length = data[DATA_WIDTH-1:2], dest addr = data[1:0].
- DEPTH, 16, storage entries; power of two, >=4.
- AFULL_THRESH, DEPTH-4, occupancy at or above which almost_full asserts.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high full reset.
- soft_reset  in  1  synchronous, active-high flush; same effect as reset.
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  marks data_in as a header byte.
- data_in  in  DATA_WIDTH  write data.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy >= AFULL_THRESH.
- data_out  out  DATA_WIDTH  registered read data.
- sop_out  out  1  data_out is a header byte.
- eop_out  out  1  data_out is the last (parity) byte of its packet.
- pkt_count  out  $clog2(DEPTH)+1  complete packets held (parity written, header not yet read).
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH holds lfd_state.
- Pointers: read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH; occupancy counter 0..DEPTH.
- Priority: reset > soft_reset > normal operation.
- On reset or soft_reset (next edge):
  - pointers, occupancy, pkt_count, wr_rem, rd_rem = 0;
  - data_out = 0; sop_out, eop_out, overflow, underflow = 0;
  - flags settle to empty=1, full=0, almost_full=0;
  - memory contents are don't-care.
- Write acceptance:
  - accepted iff write_enb && !full;
  - write_enb && full -> overflow=1 for one cycle, no state change.
  - When full, a simultaneous read is still accepted and the write is still rejected.
- Read acceptance:
  - accepted iff read_enb && !empty;
  - read_enb && empty -> underflow=1 for one cycle, data_out holds.
- Simultaneous accepted read and write: occupancy unchanged.
- Read latency: 1 cycle. data_out, sop_out and eop_out update on the edge that accepts the read, and hold until the next accepted read.
- Write-side packet tracking (wr_rem, width DATA_WIDTH-2+1):
  - accepted write with lfd_state=1: wr_rem = length+1;
  - accepted write with lfd_state=0 and wr_rem>0: wr_rem decrements; when it reaches 0, the packet is complete and pkt_count increments;
  - header with length 0: the next write is the parity byte, which completes the packet;
  - header written while wr_rem!=0 (truncated packet): wr_rem reloads and the truncated packet is never counted.
- Read-side tracking (rd_rem):
  - reading an entry with tag=1: sop_out=1 and rd_rem = length+1;
  - each subsequent accepted read decrements rd_rem; the read that brings rd_rem from 1 to 0 sets eop_out=1 and decrements pkt_count.
- pkt_count:
  - increment and decrement in the same cycle -> unchanged;
  - never decrements below 0; pkt_count is only ever meaningful for well-formed traffic.
- Flags full, empty and almost_full are combinational from the occupancy register.

Test Plan:
1. DATA_WIDTH=8, DEPTH=16: reset=1 for one edge -> empty=1, full=0, pkt_count=0, data_out=8'h00.
2. Write header 8'h11 (len 4, addr 01) with lfd_state=1, then 8'hA1..8'hA4, then parity 8'h5C -> pkt_count goes 0->1 on the edge writing 8'h5C. Read 6 entries -> first read data_out=8'h11 with sop_out=1; sixth read data_out=8'h5C with eop_out=1; pkt_count=0; empty=1.
3. Write 12 bytes -> almost_full=1 at occupancy 12, full=0. Write 4 more -> full=1. 17th write -> overflow=1 for one cycle, occupancy stays 16. Read+write same cycle while full -> read accepted, overflow=1, occupancy=15.
4. Header 8'h02 (len 0) then parity 8'hFF -> pkt_count=1 after 2 writes. Reading both -> sop_out then eop_out on consecutive reads.
5. Write header 8'h21 plus 3 payload bytes, assert soft_reset for one cycle -> empty=1, pkt_count=0, data_out=0. Read -> underflow=1, data_out stays 0.
6. Occupancy 8, read_enb and write_enb held 20 cycles across pointer wrap -> occupancy stays 8, data out in write order, no overflow or underflow.

Source files
------------

// File: rtl/router_pkt_fifo_if.sv
// Handshake and status bundle between the router FSM (master) and one
// per-port packet FIFO (slave).
interface router_pkt_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  write_enb;
    logic                  read_enb;
    logic                  lfd_state;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  sop_out;
    logic                  eop_out;
    logic [CW-1:0]         pkt_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  full, empty, almost_full, data_out, sop_out, eop_out,
               pkt_count, overflow, underflow
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output full, empty, almost_full, data_out, sop_out, eop_out,
               pkt_count, overflow, underflow
    );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware per-port output FIFO: stores header-tagged bytes, counts complete
// packets, and marks start/end of packet on the registered read port.
module router_pkt_fifo #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
    input logic              clock,
    input logic              reset,
    input logic              soft_reset,
    router_pkt_fifo_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = DATA_WIDTH - 2;
    localparam int unsigned RW = LW + 1;

    // Bit DATA_WIDTH of each entry is the header tag.
    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [DATA_WIDTH:0]   rd_entry;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         occ_q, occ_d, pkt_q, pkt_d;
    logic [RW-1:0]         wr_rem_q, wr_rem_d, rd_rem_q, rd_rem_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  sop_q, sop_d, eop_q, eop_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  full, empty, wr_acc, rd_acc, pkt_inc, pkt_dec;

    assign full  = (occ_q == CW'(DEPTH));
    assign empty = (occ_q == '0);

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (occ_q >= CW'(AFULL_THRESH));
    assign bus.data_out    = dout_q;
    assign bus.sop_out     = sop_q;
    assign bus.eop_out     = eop_q;
    assign bus.pkt_count   = pkt_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        pkt_d    = pkt_q;
        wr_rem_d = wr_rem_q;
        rd_rem_d = rd_rem_q;
        dout_d   = dout_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        pkt_inc  = 1'b0;
        pkt_dec  = 1'b0;
        rd_entry = mem_q[rd_ptr_q];

        wr_acc = bus.write_enb && !full;
        rd_acc = bus.read_enb && !empty;
        ovf_d  = bus.write_enb && full;
        udf_d  = bus.read_enb && empty;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (bus.lfd_state) begin
                // Reloading here also discards any truncated packet in progress.
                wr_rem_d = RW'(bus.data_in[DATA_WIDTH-1:2]) + RW'(1);
            end else if (wr_rem_q != '0) begin
                wr_rem_d = wr_rem_q - RW'(1);
                pkt_inc  = (wr_rem_q == RW'(1));
            end
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dout_d   = rd_entry[DATA_WIDTH-1:0];
            sop_d    = rd_entry[DATA_WIDTH];
            eop_d    = 1'b0;
            if (rd_entry[DATA_WIDTH]) begin
                rd_rem_d = RW'(rd_entry[DATA_WIDTH-1:2]) + RW'(1);
            end else if (rd_rem_q != '0) begin
                rd_rem_d = rd_rem_q - RW'(1);
                eop_d    = (rd_rem_q == RW'(1));
                pkt_dec  = eop_d;
            end
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        if (pkt_inc && !pkt_dec) begin
            pkt_d = pkt_q + CW'(1);
        end else if (!pkt_inc && pkt_dec && (pkt_q != '0)) begin
            pkt_d = pkt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            pkt_q    <= '0;
            wr_rem_q <= '0;
            rd_rem_q <= '0;
            dout_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            pkt_q    <= pkt_d;
            wr_rem_q <= wr_rem_d;
            rd_rem_q <= rd_rem_d;
            dout_q   <= dout_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage needs no reset; a flush simply rewinds the pointers.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= {bus.lfd_state, bus.data_in};
        end
    end
endmodule
